frame_row_buffer: RTL and testbench

- Parametrised, double-buffered row store between game logic (producer) and the LCD screen driver (consumer).
- Generalises the fixed 8 x 40-bit row bus to N_ROWS x ROW_W.
- Producer writes rows into the back buffer over a valid/ready handshake, then commits the frame.
- Buffers swap only on the display's frame-start pulse, so the screen never shows a half-written frame.

---
 rtl/frame_pkg.sv | 14 +
 rtl/frame_row_buffer_if.sv | 32 +++
 rtl/row_bank.sv | 45 ++++
 rtl/frame_row_buffer.sv | 131 +++++++++++++
 tb/tb_frame_row_buffer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared state encoding and default frame geometry for the row buffer
package frame_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PENDING = 2'd1,
        CLEAR   = 2'd2
    } state_t;

    localparam int DEF_N_ROWS = 8;
    localparam int DEF_ROW_W  = 40;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/frame_row_buffer_if.sv
// rtl/frame_row_buffer_if.sv - producer row-write channel (valid/ready with last-row commit)
interface frame_row_buffer_if
    import frame_pkg::*;
#(
    parameter int N_ROWS = DEF_N_ROWS,
    parameter int ROW_W  = DEF_ROW_W
);
    localparam int RIDX_W = $clog2(N_ROWS);

    logic              wr_valid;
    logic              wr_ready;
    logic [RIDX_W-1:0] wr_row;
    logic [ROW_W-1:0]  wr_data;
    logic              wr_last;

    modport master (
        output wr_valid,
        output wr_row,
        output wr_data,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_row,
        input  wr_data,
        input  wr_last,
        output wr_ready
    );

endinterface

// File: rtl/row_bank.sv
// rtl/row_bank.sv - one N_ROWS x ROW_W register bank with write, registered read and row clear
module row_bank
    import frame_pkg::*;
#(
    parameter int  N_ROWS = DEF_N_ROWS,
    parameter int  ROW_W  = DEF_ROW_W,
    localparam int RIDX_W = $clog2(N_ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [RIDX_W-1:0] wr_row,
    input  logic [ROW_W-1:0]  wr_data,
    input  logic              clr_en,
    input  logic [RIDX_W-1:0] clr_row,
    input  logic [RIDX_W-1:0] rd_row,
    output logic [ROW_W-1:0]  rd_data
);

    logic [ROW_W-1:0] mem [N_ROWS];
    logic             wr_hit;
    logic             rd_hit;

    // Row indices can encode values past the last row when N_ROWS is not a power of two.
    assign wr_hit = {1'b0, wr_row} < (RIDX_W+1)'(N_ROWS);
    assign rd_hit = {1'b0, rd_row} < (RIDX_W+1)'(N_ROWS);

    // Storage update and registered read; clear wins over write (they never coincide in use).
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_ROWS; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (clr_en) begin
                mem[clr_row] <= '0;
            end else if (wr_en && wr_hit) begin
                mem[wr_row] <= wr_data;
            end
            rd_data <= rd_hit ? mem[rd_row] : '0;
        end
    end

endmodule

// File: rtl/frame_row_buffer.sv
// rtl/frame_row_buffer.sv - double-buffered row store, swaps on frame_start; FRAME_ROW_BUFFER_CLEAR_EN zeroes the new back bank after each swap
module frame_row_buffer
    import frame_pkg::*;
#(
    parameter int  N_ROWS = DEF_N_ROWS,
    parameter int  ROW_W  = DEF_ROW_W,
    parameter int  CNT_W  = DEF_CNT_W,
    localparam int RIDX_W = $clog2(N_ROWS)
) (
    input  logic                     clk,
    input  logic                     rst,
    frame_row_buffer_if.slave        wr_if,
    input  logic                     frame_start,
    input  logic [RIDX_W-1:0]        rd_row,
    output logic [ROW_W-1:0]         rd_data,
    output logic                     commit_pending,
    output logic                     front_sel,
    output logic [CNT_W-1:0]         frame_count
);

    state_t            state;
    state_t            state_n;
    logic              accept;
    logic              swap;
    logic              clr_en;
    logic [RIDX_W-1:0] clr_row;
    logic              rd_sel;
    logic [ROW_W-1:0]  rd_data0;
    logic [ROW_W-1:0]  rd_data1;

`ifdef FRAME_ROW_BUFFER_CLEAR_EN
    logic [RIDX_W-1:0] clr_idx;
    assign clr_row = clr_idx;
`else
    assign clr_row = '0;
`endif

    assign wr_if.wr_ready = rst && (state == FILL);
    assign accept         = wr_if.wr_valid && wr_if.wr_ready;
    assign commit_pending = (state == PENDING);

    // Next-state: commit on the last accepted row, swap only from PENDING on frame_start.
    always_comb begin
        state_n = state;
        swap    = 1'b0;
        clr_en  = 1'b0;
        case (state)
            FILL: begin
                if (accept && wr_if.wr_last) begin
                    state_n = PENDING;
                end
            end
            PENDING: begin
                if (frame_start) begin
                    swap = 1'b1;
`ifdef FRAME_ROW_BUFFER_CLEAR_EN
                    state_n = CLEAR;
`else
                    state_n = FILL;
`endif
                end
            end
`ifdef FRAME_ROW_BUFFER_CLEAR_EN
            CLEAR: begin
                clr_en = 1'b1;
                if (clr_idx == RIDX_W'(N_ROWS - 1)) begin
                    state_n = FILL;
                end
            end
`endif
            default: state_n = FILL;
        endcase
    end

    // State register, bank selection, swap counter and read-mux select (pre-edge front_sel).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FILL;
            front_sel   <= 1'b0;
            frame_count <= '0;
            rd_sel      <= 1'b0;
        end else begin
            state  <= state_n;
            rd_sel <= front_sel;
            if (swap) begin
                front_sel   <= ~front_sel;
                frame_count <= frame_count + CNT_W'(1);
            end
        end
    end

`ifdef FRAME_ROW_BUFFER_CLEAR_EN
    // Clear sweep index, ascending from row 0 while in CLEAR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_idx <= '0;
        end else if (clr_en && (clr_idx != RIDX_W'(N_ROWS - 1))) begin
            clr_idx <= clr_idx + RIDX_W'(1);
        end else begin
            clr_idx <= '0;
        end
    end
`endif

    assign rd_data = rd_sel ? rd_data1 : rd_data0;

    row_bank #(.N_ROWS(N_ROWS), .ROW_W(ROW_W)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept && front_sel),
        .wr_row  (wr_if.wr_row),
        .wr_data (wr_if.wr_data),
        .clr_en  (clr_en && front_sel),
        .clr_row (clr_row),
        .rd_row  (rd_row),
        .rd_data (rd_data0)
    );

    row_bank #(.N_ROWS(N_ROWS), .ROW_W(ROW_W)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept && !front_sel),
        .wr_row  (wr_if.wr_row),
        .wr_data (wr_if.wr_data),
        .clr_en  (clr_en && !front_sel),
        .clr_row (clr_row),
        .rd_row  (rd_row),
        .rd_data (rd_data1)
    );

endmodule

// File: tb/tb_frame_row_buffer.sv
// tb/tb_frame_row_buffer.sv - randomized self-checking bench for frame_row_buffer against a frame-level model
module tb_frame_row_buffer;

    localparam int N  = 6;
    localparam int W  = 40;
    localparam int CW = 4;
    localparam int RW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic [RW-1:0] rd_row;
    logic [W-1:0]  rd_data;
    logic          commit_pending;
    logic          front_sel;
    logic [CW-1:0] frame_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    frame_row_buffer_if #(.N_ROWS(N), .ROW_W(W)) wif ();

    frame_row_buffer #(.N_ROWS(N), .ROW_W(W), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst_n),
        .wr_if          (wif),
        .frame_start    (frame_start),
        .rd_row         (rd_row),
        .rd_data        (rd_data),
        .commit_pending (commit_pending),
        .front_sel      (front_sel),
        .frame_count    (frame_count)
    );

    // Frame-level model: two row images, which one is shown, commit flag, swap count, busy cycles.
    logic [W-1:0] m_img [2][N];
    int           m_front;
    bit           m_pending;
    int           m_count;
    int           m_busy;
    logic [W-1:0] m_rd;

    function automatic bit m_ready();
        return rst_n && !m_pending && (m_busy == 0);
    endfunction

    task automatic tick();
        logic [W-1:0] rv;
        bit           acc;
        @(posedge clk);
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < N; r++) m_img[b][r] = '0;
            m_front = 0; m_pending = 0; m_count = 0; m_busy = 0; m_rd = '0;
        end else begin
            rv  = (int'(rd_row) < N) ? m_img[m_front][rd_row] : '0;
            acc = wif.wr_valid && m_ready();
            if (m_busy > 0) m_busy--;
            if (acc) begin
                if (int'(wif.wr_row) < N) m_img[1-m_front][wif.wr_row] = wif.wr_data;
                if (wif.wr_last) m_pending = 1;
            end else if (m_pending && frame_start) begin
                m_front   = 1 - m_front;
                m_count   = (m_count + 1) % (1 << CW);
                m_pending = 0;
`ifdef FRAME_ROW_BUFFER_CLEAR_EN
                for (int r = 0; r < N; r++) m_img[1-m_front][r] = '0;
                m_busy = N;
`endif
            end
            m_rd = rv;
        end
        #1;
    endtask

    function automatic logic [W-1:0] rnd_row();
        return {$urandom, $urandom} & {W{1'b1}};
    endfunction

    task automatic put(input int row, input logic [W-1:0] d, input bit last);
        wif.wr_valid = 1'b1; wif.wr_row = row[RW-1:0]; wif.wr_data = d; wif.wr_last = last;
        tick();
        wif.wr_valid = 1'b0; wif.wr_last = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!wif.wr_ready && n < 40) begin tick(); n++; end
        ok = wif.wr_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wif.wr_valid = 1'b1; wif.wr_row = 3'(i); wif.wr_data = rnd_row(); wif.wr_last = 1'b1;
            tick();
            total++; if (wif.wr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b exp 0", wif.wr_ready); end
        end
        wif.wr_valid = 1'b0; wif.wr_last = 1'b0;
        total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        total++; if (frame_count !== '0) begin bad++; $display("FAIL reset_count got %0d exp 0", frame_count); end
        total++; if (front_sel !== 1'b0) begin bad++; $display("FAIL reset_front got %b exp 0", front_sel); end
        total++; if (commit_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got %b exp 0", commit_pending); end
        rst_n = 1'b1;
        #1;
        total++; if (wif.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got %b exp 1", wif.wr_ready); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < N; i++) put(i, W'(i + 1), i == N - 1);
        total++; if (commit_pending !== 1'b1) begin bad++; $display("FAIL basic_pending got %b exp 1", commit_pending); end
        total++; if (wif.wr_ready !== 1'b0) begin bad++; $display("FAIL basic_ready got %b exp 0", wif.wr_ready); end
        rd_row = 3'd3;
        pulse_fs();
        total++; if (front_sel !== 1'b1) begin bad++; $display("FAIL basic_front got %b exp 1", front_sel); end
        total++; if (frame_count !== CW'(1)) begin bad++; $display("FAIL basic_count got %0d exp 1", frame_count); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL basic_swap_edge_rd got %h exp 0", rd_data); end
        tick();
        total++; if (rd_data !== W'(4)) begin bad++; $display("FAIL basic_rd3 got %h exp 4", rd_data); end
    endtask

    task automatic test_tear_free();
        bit ok;
        wait_ready(ok);
        total++; if (!ok) begin bad++; $display("FAIL tear_wait_ready got 0 exp 1"); end
        for (int i = 0; i < N; i++) put(i, rnd_row(), i == N - 1);
        for (int c = 0; c < 20; c++) begin
            wif.wr_valid = 1'b1; wif.wr_row = 3'($urandom_range(0, N - 1)); wif.wr_data = rnd_row();
            rd_row = 3'($urandom_range(0, 7));
            tick();
            total++; if (wif.wr_ready !== 1'b0) begin bad++; $display("FAIL tear_ready c=%0d got %b exp 0", c, wif.wr_ready); end
            total++; if (commit_pending !== 1'b1) begin bad++; $display("FAIL tear_pending c=%0d got %b exp 1", c, commit_pending); end
            total++; if (rd_data !== m_rd) begin bad++; $display("FAIL tear_rd c=%0d got %h exp %h", c, rd_data, m_rd); end
        end
        wif.wr_valid = 1'b0;
        pulse_fs();
        total++; if (front_sel !== m_front[0]) begin bad++; $display("FAIL tear_swap_front got %b exp %b", front_sel, m_front[0]); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        int f0, c0;
        wait_ready(ok);
        total++; if (!ok) begin bad++; $display("FAIL sim_wait_ready got 0 exp 1"); end
        for (int i = 0; i < N - 1; i++) put(i, rnd_row(), 1'b0);
        f0 = m_front; c0 = m_count;
        frame_start = 1'b1;
        put(N - 1, rnd_row(), 1'b1);
        frame_start = 1'b0;
        total++; if (front_sel !== f0[0]) begin bad++; $display("FAIL sim_no_swap_front got %b exp %b", front_sel, f0[0]); end
        total++; if (frame_count !== CW'(c0)) begin bad++; $display("FAIL sim_no_swap_count got %0d exp %0d", frame_count, c0); end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (commit_pending !== 1'b1) begin bad++; $display("FAIL sim_pending c=%0d got %b exp 1", c, commit_pending); end
        end
        pulse_fs();
        total++; if (front_sel !== !f0[0]) begin bad++; $display("FAIL sim_swap_front got %b exp %b", front_sel, !f0[0]); end
        total++; if (frame_count !== CW'(c0 + 1)) begin bad++; $display("FAIL sim_swap_count got %0d exp %0d", frame_count, CW'(c0 + 1)); end
    endtask

    task automatic test_out_of_range();
        bit ok;
        wait_ready(ok);
        total++; if (!ok) begin bad++; $display("FAIL oor_wait_ready got 0 exp 1"); end
        put(7, rnd_row(), 1'b1);
        total++; if (commit_pending !== 1'b1) begin bad++; $display("FAIL oor_pending got %b exp 1", commit_pending); end
        rd_row = 3'd7;
        tick();
        total++; if (rd_data !== '0) begin bad++; $display("FAIL oor_rd7 got %h exp 0", rd_data); end
        pulse_fs();
        for (int r = 0; r < 8; r++) begin
            rd_row = 3'(r);
            tick();
            total++; if (rd_data !== m_rd) begin bad++; $display("FAIL oor_rows r=%0d got %h exp %h", r, rd_data, m_rd); end
        end
    endtask

    task automatic test_clear_or_stale();
        bit ok;
        int n, exp_busy;
        wait_ready(ok);
        total++; if (!ok) begin bad++; $display("FAIL clr_wait_ready got 0 exp 1"); end
        for (int i = 0; i < N; i++) put(i, rnd_row(), i == N - 1);
        pulse_fs();
        n = 0;
        while (!wif.wr_ready && n < 30) begin tick(); n++; end
`ifdef FRAME_ROW_BUFFER_CLEAR_EN
        exp_busy = N;
`else
        exp_busy = 0;
`endif
        total++; if (n != exp_busy) begin bad++; $display("FAIL clr_busy_cycles got %0d exp %0d", n, exp_busy); end
        put(0, rnd_row(), 1'b1);
        pulse_fs();
        for (int r = 1; r < N; r++) begin
            rd_row = 3'(r);
            tick();
            total++; if (rd_data !== m_rd) begin bad++; $display("FAIL clr_rows r=%0d got %h exp %h", r, rd_data, m_rd); end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        wait_ready(ok);
        put(0, rnd_row(), 1'b0);
        put(1, rnd_row(), 1'b1);
        total++; if (commit_pending !== 1'b1) begin bad++; $display("FAIL mrst_pre_pending got %b exp 1", commit_pending); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        total++; if (commit_pending !== 1'b0) begin bad++; $display("FAIL mrst_pending got %b exp 0", commit_pending); end
        total++; if (wif.wr_ready !== 1'b1) begin bad++; $display("FAIL mrst_ready got %b exp 1", wif.wr_ready); end
        pulse_fs();
        total++; if (front_sel !== 1'b0) begin bad++; $display("FAIL mrst_no_swap got %b exp 0", front_sel); end
        for (int r = 0; r < N; r++) begin
            rd_row = 3'(r);
            tick();
            total++; if (rd_data !== '0) begin bad++; $display("FAIL mrst_rows r=%0d got %h exp 0", r, rd_data); end
        end
    endtask

    task automatic test_count_wrap();
        bit ok;
        int c0;
        c0 = m_count;
        for (int k = 1; k <= 18; k++) begin
            wait_ready(ok);
            put(k % N, rnd_row(), 1'b1);
            pulse_fs();
            total++; if (frame_count !== CW'((c0 + k) % (1 << CW))) begin bad++; $display("FAIL wrap_count k=%0d got %0d exp %0d", k, frame_count, (c0 + k) % (1 << CW)); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            wif.wr_valid = ($urandom_range(0, 3) != 0);
            wif.wr_row   = 3'($urandom_range(0, 7));
            wif.wr_data  = rnd_row();
            wif.wr_last  = ($urandom_range(0, 5) == 0);
            frame_start  = ($urandom_range(0, 7) == 0);
            rd_row       = 3'($urandom_range(0, 7));
            tick();
            total++; if (rd_data !== m_rd) begin bad++; $display("FAIL rand_rd c=%0d got %h exp %h", c, rd_data, m_rd); end
            total++; if (wif.wr_ready !== m_ready()) begin bad++; $display("FAIL rand_ready c=%0d got %b exp %b", c, wif.wr_ready, m_ready()); end
            total++; if (commit_pending !== m_pending) begin bad++; $display("FAIL rand_pending c=%0d got %b exp %b", c, commit_pending, m_pending); end
            total++; if (front_sel !== m_front[0]) begin bad++; $display("FAIL rand_front c=%0d got %b exp %b", c, front_sel, m_front[0]); end
            total++; if (frame_count !== CW'(m_count)) begin bad++; $display("FAIL rand_count c=%0d got %0d exp %0d", c, frame_count, m_count); end
        end
        wif.wr_valid = 1'b0; wif.wr_last = 1'b0; frame_start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; rd_row = '0;
        wif.wr_valid = 1'b0; wif.wr_row = '0; wif.wr_data = '0; wif.wr_last = 1'b0;
        test_reset();
        test_basic();
        test_tear_free();
        test_simultaneous();
        test_out_of_range();
        test_clear_or_stale();
        test_mid_reset();
        test_count_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
